// File: rtl/r2sdf_bf_stage.sv
// rtl/r2sdf_bf_stage.sv - radix-2 single-delay-feedback butterfly stage
//
// Streams natural-order complex samples, one per clock, through a radix-2
// SDF butterfly. The feedback memory is an external shift register of DELAY
// stages that shifts every clock: whatever is driven on fb_wr_data in cycle t
// comes back on fb_rd_data in cycle t+DELAY.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid            input sample valid
//   in_re, in_im        input sample, signed WIDTH bits per component
//   fb_wr_data          {re,im} to the delay-line input (combinational)
//   fb_rd_data          {re,im} from the delay-line output
//   out_valid           registered output valid
//   out_re, out_im      registered output, signed WIDTH+1 bits
//   tw_en               output is a difference and needs a twiddle multiply
//   tw_addr             twiddle index k for the current output
//   err                 one-cycle protocol-error pulse
module r2sdf_bf_stage #(
    parameter int WIDTH = 16,
    parameter int DELAY = 4,
    parameter int TW_AW = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_re,
    input  logic [WIDTH-1:0]       in_im,
    output logic [2*(WIDTH+1)-1:0] fb_wr_data,
    input  logic [2*(WIDTH+1)-1:0] fb_rd_data,
    output logic                   out_valid,
    output logic [WIDTH:0]         out_re,
    output logic [WIDTH:0]         out_im,
    output logic                   tw_en,
    output logic [TW_AW-1:0]       tw_addr,
    output logic                   err
);

    localparam int BW = WIDTH + 1;
    localparam int CW = $clog2(2 * DELAY);
    localparam logic [CW-1:0] D_CNT = CW'(DELAY);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx, cnt_inc;
    logic                phase;

    logic signed [BW-1:0] a_re, a_im, b_re, b_im;
    logic signed [BW-1:0] sum_re, sum_im, dif_re, dif_im;
    logic signed [BW-1:0] wr_re, wr_im, re_nx, im_nx;
    logic                 valid_nx, te_nx, err_nx;
    logic [TW_AW-1:0]     ta_nx;

    assign b_re = {in_re[WIDTH-1], in_re};
    assign b_im = {in_im[WIDTH-1], in_im};
    assign a_re = fb_rd_data[2*BW-1:BW];
    assign a_im = fb_rd_data[BW-1:0];

    assign sum_re = a_re + b_re;
    assign sum_im = a_im + b_im;
    assign dif_re = a_re - b_re;
    assign dif_im = a_im - b_im;

    assign cnt_inc = cnt + CW'(1);
    assign phase   = (cnt >= D_CNT);

    assign fb_wr_data = {wr_re, wr_im};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        valid_nx = 1'b0;
        re_nx    = '0;
        im_nx    = '0;
        te_nx    = 1'b0;
        ta_nx    = '0;
        err_nx   = 1'b0;
        wr_re    = '0;
        wr_im    = '0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    wr_re    = b_re;
                    wr_im    = b_im;
                    cnt_nx   = cnt_inc;
                    state_nx = (cnt_inc == D_CNT) ? RUN : FILL;
                end
            end
            FILL: begin
                // Delay contents are stale here, so nothing is emitted.
                if (in_valid) begin
                    wr_re  = b_re;
                    wr_im  = b_im;
                    cnt_nx = cnt_inc;
                    if (cnt_inc == D_CNT) begin
                        state_nx = RUN;
                    end
                end else begin
                    err_nx   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (in_valid) begin
                    valid_nx = 1'b1;
                    cnt_nx   = cnt_inc;
                    if (phase) begin
                        wr_re = dif_re;
                        wr_im = dif_im;
                        re_nx = sum_re;
                        im_nx = sum_im;
                    end else begin
                        // Previous block's difference comes back while the
                        // new block's first half is written in.
                        wr_re = b_re;
                        wr_im = b_im;
                        re_nx = a_re;
                        im_nx = a_im;
                        te_nx = 1'b1;
                        ta_nx = TW_AW'(cnt);
                    end
                end else if (cnt == '0) begin
                    // Clean stop at the block boundary: this cycle already
                    // drains difference k=0, so it is the first flush cycle.
                    valid_nx = 1'b1;
                    re_nx    = a_re;
                    im_nx    = a_im;
                    te_nx    = 1'b1;
                    if (cnt_inc == D_CNT) begin
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx   = cnt_inc;
                        state_nx = FLUSH;
                    end
                end else begin
                    // Mid-block gap: partial block is abandoned.
                    err_nx   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            FLUSH: begin
                valid_nx = 1'b1;
                re_nx    = a_re;
                im_nx    = a_im;
                te_nx    = 1'b1;
                ta_nx    = TW_AW'(cnt);
                err_nx   = in_valid;
                if (cnt_inc == D_CNT) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            tw_en     <= 1'b0;
            tw_addr   <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            out_valid <= valid_nx;
            out_re    <= re_nx;
            out_im    <= im_nx;
            tw_en     <= te_nx;
            tw_addr   <= ta_nx;
            err       <= err_nx;
        end
    end

endmodule
